// File: rtl/headercap_pkg.sv
// Shared header-capture constants: field lengths, the concatenated key width
// and the statistics counter width.
package headercap_pkg;

  localparam int MAC_LEN      = 48;
  localparam int IPV4_LEN     = 32;
  localparam int L4_PORT_LEN  = 16;
  localparam int ETHTYPE_LEN  = 16;
  localparam int IP_LEN_LEN   = 16;
  localparam int IP_PROTO_LEN = 8;

  // Key = dst/src MAC, src/dst IPv4, src/dst L4 port, EtherType, IP length, IP protocol.
  localparam int CONCAT_WIDTH = 2 * MAC_LEN + 2 * IPV4_LEN + 2 * L4_PORT_LEN
                              + ETHTYPE_LEN + IP_LEN_LEN + IP_PROTO_LEN;

  localparam int STATS_W = 32;

endpackage

// File: rtl/header_arbiter_rr_picker.sv
// Combinational round-robin picker: rotates the request vector by ptr using a
// double-width shift, then priority-encodes the lowest set bit.
module rr_picker #(
  parameter  int NUM_PORTS = 4,
  localparam int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [PORT_W-1:0]    gnt_idx,
  output logic                 any
);

  localparam logic [PORT_W:0] NP = (PORT_W + 1)'(NUM_PORTS);

  logic [2*NUM_PORTS-1:0] dbl;
  logic [NUM_PORTS-1:0]   rot;
  logic [PORT_W-1:0]      off;
  logic [PORT_W:0]        sum;

  assign dbl = {req, req} >> ptr;
  assign rot = dbl[NUM_PORTS-1:0];
  assign any = |req;

  // Descending scan so the lowest set bit (closest to ptr) wins.
  always_comb begin
    off = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (rot[i]) off = PORT_W'(i);
    end
  end

  always_comb begin
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NP) sum = sum - NP;
  end

  assign gnt_idx = sum[PORT_W-1:0];

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_gnt
    assign gnt[gi] = any && (gnt_idx == PORT_W'(gi));
  end

endmodule

// File: rtl/header_arbiter.sv
// Round-robin merge of per-port header keys onto one registered key bus.
// Define HEADER_ARB_STATS_EN to add per-port saturating grant counters.
module header_arbiter
  import headercap_pkg::*;
#(
  parameter  int NUM_PORTS    = 4,
  parameter  int CONCAT_WIDTH = headercap_pkg::CONCAT_WIDTH,
  localparam int PORT_W       = $clog2(NUM_PORTS)
) (
  input  logic                           clk,
  input  logic                           reset,
`ifdef HEADER_ARB_STATS_EN
  input  logic [PORT_W-1:0]              stats_sel,
  output logic [STATS_W-1:0]             stats_count,
`endif
  input  logic [NUM_PORTS*CONCAT_WIDTH-1:0] in_concat,
  input  logic [NUM_PORTS-1:0]           in_valid,
  output logic [NUM_PORTS-1:0]           in_ready,
  output logic [CONCAT_WIDTH-1:0]        key_data,
  output logic [PORT_W-1:0]              key_port,
  output logic                           key_valid,
  input  logic                           key_ready
);

  localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(NUM_PORTS - 1);

  logic [CONCAT_WIDTH-1:0] key_data_q, key_data_d;
  logic [PORT_W-1:0]       key_port_q, key_port_d;
  logic                    key_valid_q, key_valid_d;
  logic [PORT_W-1:0]       rr_ptr_q, rr_ptr_d;

  logic [NUM_PORTS-1:0] pick_gnt;
  logic [PORT_W-1:0]    pick_idx;
  logic                 pick_any;
  logic                 can_load;
  logic                 grant;

  rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  assign can_load = !key_valid_q || key_ready;
  // Reset blocks grants so nothing is consumed from a source while clearing.
  assign grant    = can_load && pick_any && !reset;
  assign in_ready = grant ? pick_gnt : '0;

  always_comb begin
    key_data_d  = key_data_q;
    key_port_d  = key_port_q;
    key_valid_d = key_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (grant) begin
      key_data_d  = in_concat[pick_idx*CONCAT_WIDTH +: CONCAT_WIDTH];
      key_port_d  = pick_idx;
      key_valid_d = 1'b1;
      rr_ptr_d    = (pick_idx == LAST_PORT) ? '0 : pick_idx + 1'b1;
    end else if (key_ready) begin
      key_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_data_q  <= '0;
      key_port_q  <= '0;
      key_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      key_data_q  <= key_data_d;
      key_port_q  <= key_port_d;
      key_valid_q <= key_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign key_data  = key_data_q;
  assign key_port  = key_port_q;
  assign key_valid = key_valid_q;

`ifdef HEADER_ARB_STATS_EN
  localparam logic [PORT_W:0] NP = (PORT_W + 1)'(NUM_PORTS);

  logic [STATS_W-1:0] cnt_w [NUM_PORTS];
  logic [STATS_W-1:0] stats_count_q;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cnt
    logic [STATS_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
      end else if (grant && (pick_idx == PORT_W'(gi)) && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign cnt_w[gi] = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stats_count_q <= '0;
    end else begin
      stats_count_q <= ({1'b0, stats_sel} < NP) ? cnt_w[stats_sel] : '0;
    end
  end

  assign stats_count = stats_count_q;
`endif

endmodule

// File: tb/tb_header_arbiter.sv
// Directed bench for header_arbiter (NUM_PORTS=4); stats checks are built only
// when HEADER_ARB_STATS_EN is defined.
module tb_header_arbiter;
  import headercap_pkg::*;

  localparam int NP = 4;
  localparam int W  = CONCAT_WIDTH;
  localparam int PW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP*W-1:0]   in_concat;
  logic [NP-1:0]     in_valid;
  logic [NP-1:0]     in_ready;
  logic [W-1:0]      key_data;
  logic [PW-1:0]     key_port;
  logic              key_valid;
  logic              key_ready;
`ifdef HEADER_ARB_STATS_EN
  logic [PW-1:0]     stats_sel;
  logic [STATS_W-1:0] stats_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  header_arbiter #(.NUM_PORTS(NP)) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef HEADER_ARB_STATS_EN
    .stats_sel   (stats_sel),
    .stats_count (stats_count),
`endif
    .in_concat   (in_concat),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .key_data    (key_data),
    .key_port    (key_port),
    .key_valid   (key_valid),
    .key_ready   (key_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, got);
    end
  endtask

  function automatic logic [W-1:0] rep(input logic [7:0] b);
    return {(W/8){b}};
  endfunction

  task automatic set_key(input int p, input logic [7:0] b);
    in_concat[p*W +: W] = rep(b);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input int p, input logic [7:0] b);
    check({tag, ".valid"}, 256'(key_valid), 256'(v));
    check({tag, ".port"},  256'(key_port),  256'(p));
    check({tag, ".data"},  256'(key_data),  256'(rep(b)));
  endtask

  initial begin
    reset     = 1'b1;
    in_concat = '0;
    in_valid  = 4'hF;
    key_ready = 1'b0;
`ifdef HEADER_ARB_STATS_EN
    stats_sel = '0;
`endif
    for (int i = 0; i < NP; i++) set_key(i, 8'h10 + 8'(i));

    // Reset state; valid requests during reset must not be granted.
    step();
    #1 check("rst.in_ready", 256'(in_ready), 256'(4'b0000));
    step();
    check("rst.valid", 256'(key_valid), 256'(0));
    check("rst.port",  256'(key_port),  256'(0));
    check("rst.data",  256'(key_data),  256'(0));

    // All ports valid, key_ready high: 0,1,2,3,0 back-to-back.
    reset     = 1'b0;
    key_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1 check($sformatf("rr%0d.in_ready", k), 256'(in_ready), 256'(4'b0001 << (k % 4)));
      step();
      check_out($sformatf("rr%0d", k), 1'b1, k % 4, 8'h10 + 8'(k % 4));
    end

    // Backpressure: 5 stalled cycles hold port 0's entry, then port 1 with no bubble.
    key_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 check($sformatf("bp%0d.in_ready", k), 256'(in_ready), 256'(4'b0000));
      step();
      check_out($sformatf("bp%0d", k), 1'b1, 0, 8'h10);
    end
    key_ready = 1'b1;
    #1 check("bp.release.in_ready", 256'(in_ready), 256'(4'b0010));
    step();
    check_out("bp.release", 1'b1, 1, 8'h11);

    // Wrap: grant port 3, then with ports 0 and 3 valid port 0 wins.
    in_valid = 4'b1000;
    #1 check("wrap.g3.in_ready", 256'(in_ready), 256'(4'b1000));
    step();
    check_out("wrap.g3", 1'b1, 3, 8'h13);
    in_valid = 4'b1001;
    #1 check("wrap.g0.in_ready", 256'(in_ready), 256'(4'b0001));
    step();
    check_out("wrap.g0", 1'b1, 0, 8'h10);
    in_valid = 4'b1000;
    #1 check("wrap.g3b.in_ready", 256'(in_ready), 256'(4'b1000));
    step();
    check_out("wrap.g3b", 1'b1, 3, 8'h13);

    // Single port 2 with key 0xA5..., then drain.
    set_key(2, 8'hA5);
    in_valid = 4'b0100;
    #1 check("single.in_ready", 256'(in_ready), 256'(4'b0100));
    step();
    in_valid = 4'b0000;
    #1 check("single.in_ready_after", 256'(in_ready), 256'(4'b0000));
    check_out("single", 1'b1, 2, 8'hA5);
    step();
    check("single.drain.valid", 256'(key_valid), 256'(0));

    // Reset mid-stream with a stalled entry; pointer returns to 0.
    in_valid = 4'b0010;
    step();
    check_out("pre_rst", 1'b1, 1, 8'h11);
    key_ready = 1'b0;
    in_valid  = 4'hF;
    reset     = 1'b1;
    #1 check("midrst.in_ready", 256'(in_ready), 256'(4'b0000));
    step();
    reset     = 1'b0;
    key_ready = 1'b1;
    check_out("midrst", 1'b0, 0, 8'h00);
    #1 check("midrst.next.in_ready", 256'(in_ready), 256'(4'b0001));
    step();
    check_out("midrst.next", 1'b1, 0, 8'h10);
    in_valid = 4'b0000;
    step();

`ifdef HEADER_ARB_STATS_EN
    // Ten grants to port 1 (port 0 got one grant since reset).
    stats_sel = 2'd1;
    in_valid  = 4'b0010;
    for (int k = 0; k < 10; k++) step();
    in_valid = 4'b0000;
    step();
    step();
    check("stats.p1", 256'(stats_count), 256'(10));
    stats_sel = 2'd0;
    step();
    check("stats.p0", 256'(stats_count), 256'(1));
    stats_sel = 2'd2;
    step();
    check("stats.p2", 256'(stats_count), 256'(0));

    // Saturation from a forced near-max value.
    force dut.g_cnt[1].cnt_q = 32'hFFFF_FFFD;
    step();
    release dut.g_cnt[1].cnt_q;
    stats_sel = 2'd1;
    in_valid  = 4'b0010;
    for (int k = 0; k < 4; k++) step();
    in_valid = 4'b0000;
    step();
    step();
    check("stats.sat", 256'(stats_count), 256'(32'hFFFF_FFFF));
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
